pipe_credit_ctrl: RTL and testbench

//  Flow controller for a fixed-latency, non-stallable delay-chain datapath that

---
 rtl/pipe_credit_ctrl_if.sv | 24 ++
 rtl/pipe_credit_ctrl.sv | 97 +++++++++
 tb/tb_pipe_credit_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_ctrl_if.sv
// Handshake/credit bundle between upstream, the flow controller and the downstream buffer.
interface pipe_credit_ctrl_if #(
    parameter int unsigned CW = 4
);
    logic          s_valid;
    logic          s_ready;
    logic          issue;
    logic          out_valid;
    logic          credit_return;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] credits;
    logic [CW-1:0] in_flight;

    modport master (
        output s_valid, credit_return, flush_req,
        input  s_ready, issue, out_valid, flush_done, credits, in_flight
    );

    modport slave (
        input  s_valid, credit_return, flush_req,
        output s_ready, issue, out_valid, flush_done, credits, in_flight
    );
endinterface

// File: rtl/pipe_credit_ctrl.sv
// Credit-based admission control for a fixed-latency, non-stallable delay chain,
// with a valid pipe aligned to the chain output and a drain/flush sequence.
module pipe_credit_ctrl #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_credit_ctrl_if.slave bus
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic               s_ready;
    logic               issue;
    logic               out_valid;

    assign s_ready   = (state_q == ST_RUN) && (credits_q != '0) && !rst;
    assign issue     = bus.s_valid && s_ready;
    assign out_valid = vpipe_q[LATENCY-1];

    // Valid pipe mirrors the delay chain; counters track credits and in-flight words.
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = issue;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        credits_d = credits_q;
        if (issue && !bus.credit_return) begin
            credits_d = credits_q - CW'(1);
        end else if (!issue && bus.credit_return && (credits_q != DEPTH_C)) begin
            credits_d = credits_q + CW'(1);
        end

        in_flight_d = in_flight_q + CW'(issue) - CW'(out_valid);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((in_flight_q == '0) && !issue && !out_valid && (credits_q == DEPTH_C)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            credits_q   <= DEPTH_C;
            in_flight_q <= '0;
            vpipe_q     <= '0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            in_flight_q <= in_flight_d;
            vpipe_q     <= vpipe_d;
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.issue      = issue;
    assign bus.out_valid  = out_valid;
    assign bus.flush_done = (state_q == ST_DONE);
    assign bus.credits    = credits_q;
    assign bus.in_flight  = in_flight_q;

    // Downstream must never return a slot it was not granted.
    a_credit_overflow: assert property (
        @(posedge clk) disable iff (rst) !(bus.credit_return && (credits_q == DEPTH_C))
    );
endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Directed scoreboard bench for pipe_credit_ctrl plus a randomised LATENCY=1/DEPTH=1 build.
module tb_pipe_credit_ctrl;
    localparam int unsigned LAT = 3;
    localparam int unsigned DEP = 8;
    localparam int unsigned CW  = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ov_q[$];
    int   fd_q[$];
    int   mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_credit_ctrl_if #(.CW(CW)) bus ();
    pipe_credit_ctrl #(.LATENCY(LAT), .DEPTH(DEP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    pipe_credit_ctrl_if #(.CW(2)) bus1 ();
    pipe_credit_ctrl #(.LATENCY(1), .DEPTH(1), .CW(2)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the edge; samples are taken 3 units after.
    task automatic drive(input logic sv, input logic cr, input logic fr);
        @(posedge clk);
        #1;
        bus.s_valid       = sv;
        bus.credit_return = cr;
        bus.flush_req     = fr;
        #2;
    endtask

    task automatic exp_issue(input string name);
        chk(name, longint'(bus.issue), 1);
        ov_q.push_back(cyc + int'(LAT));
    endtask

    // Monitor: pops expected output cycles whenever the DUT presents out_valid/flush_done.
    always @(negedge clk) begin
        while (ov_q.size() > 0 && ov_q[0] < cyc) begin
            mon_e = ov_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL out_valid_missing: got no out_valid, expected at cycle %0d", mon_e);
        end
        while (fd_q.size() > 0 && fd_q[0] < cyc) begin
            mon_e = fd_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL flush_done_missing: got no flush_done, expected at cycle %0d", mon_e);
        end
        if (bus.out_valid === 1'b1) begin
            if (ov_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL out_valid_unexpected: got out_valid at cycle %0d, expected none", cyc);
            end else begin
                mon_e = ov_q.pop_front();
                chk("out_valid_cycle", cyc, mon_e);
            end
        end
        if (bus.flush_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL flush_done_unexpected: got flush_done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = fd_q.pop_front();
                chk("flush_done_cycle", cyc, mon_e);
                chk("flush_done_credits", longint'(bus.credits), DEP);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int buffered;
        int n_iss;
        int n_ov;

        rst  = 1'b1;
        rst1 = 1'b1;
        bus.s_valid = 1'b0; bus.credit_return = 1'b0; bus.flush_req = 1'b0;
        bus1.s_valid = 1'b0; bus1.credit_return = 1'b0; bus1.flush_req = 1'b0;

        // Reset state
        @(posedge clk); #3;
        chk("rst_s_ready", longint'(bus.s_ready), 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        rst1 = 1'b0;
        #2;
        chk("rst_credits", longint'(bus.credits), DEP);
        chk("rst_in_flight", longint'(bus.in_flight), 0);
        chk("rst_s_ready_run", longint'(bus.s_ready), 1);
        chk("rst_flush_done", longint'(bus.flush_done), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);

        // 1: s_valid held, no returns: 8 issues then stall at credits=0
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("t1_credits", longint'(bus.credits), (i < 8) ? (8 - i) : 0);
            if (i < 8) exp_issue("t1_issue");
            else       chk("t1_s_ready_empty", longint'(bus.s_ready), 0);
        end

        // 2: single credit return admits exactly one word
        drive(1'b1, 1'b1, 1'b0);
        chk("t2_no_issue_at_zero", longint'(bus.issue), 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t2_credits_one", longint'(bus.credits), 1);
        exp_issue("t2_issue");
        drive(1'b1, 1'b0, 1'b0);
        chk("t2_credits_zero", longint'(bus.credits), 0);
        chk("t2_stalled", longint'(bus.issue), 0);
        drive(1'b0, 1'b0, 1'b0);

        // 3: credits=2, simultaneous issue and return for 20 cycles
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_credits_start", longint'(bus.credits), 2);
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk("t3_credits_steady", longint'(bus.credits), 2);
            exp_issue("t3_issue");
            if (j >= 3) chk("t3_in_flight_full", longint'(bus.in_flight), LAT);
        end
        for (int j = 0; j < 6; j++) drive(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 1'b0);
        chk("t3_credits_home", longint'(bus.credits), DEP);
        chk("t3_in_flight_idle", longint'(bus.in_flight), 0);

        // 4: 5 issues, flush on the 5th, 5 credits back at +6..+10
        for (int j = 0; j < 15; j++) begin
            drive(j <= 5, (j >= 6) && (j <= 10), j == 4);
            if (j == 0) fd_q.push_back(cyc + 12);
            if (j < 5)        exp_issue("t4_issue");
            else if (j <= 12) chk("t4_s_ready_drain", longint'(bus.s_ready), 0);
            else              chk("t4_s_ready_run", longint'(bus.s_ready), 1);
            if (j == 5)  chk("t4_credits_low", longint'(bus.credits), 3);
            if (j == 11) chk("t4_credits_full", longint'(bus.credits), DEP);
        end

        // 5: reset while draining with two words in flight
        drive(1'b1, 1'b0, 1'b0);
        chk("t5_issue0", longint'(bus.issue), 1);
        drive(1'b1, 1'b0, 1'b1);
        chk("t5_issue1", longint'(bus.issue), 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("t5_in_flight_two", longint'(bus.in_flight), 2);
        chk("t5_s_ready_drain", longint'(bus.s_ready), 0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_in_flight_cleared", longint'(bus.in_flight), 0);
        chk("t5_credits_restored", longint'(bus.credits), DEP);
        chk("t5_out_valid_clear", longint'(bus.out_valid), 0);
        chk("t5_s_ready_run", longint'(bus.s_ready), 1);
        for (int j = 0; j < 6; j++) drive(1'b0, 1'b0, 1'b0);

        // 6: random traffic on the LATENCY=1, DEPTH=1 build with a downstream buffer model
        buffered = 0;
        n_iss    = 0;
        n_ov     = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            bus1.s_valid       = 1'($urandom_range(0, 1));
            bus1.credit_return = (buffered > 0) && ($urandom_range(0, 1) == 1);
            #2;
            chk("t6_conservation",
                longint'((int'(bus1.credits) + int'(bus1.in_flight) + buffered) <= 1), 1);
            if (bus1.issue === 1'b1)         n_iss++;
            if (bus1.out_valid === 1'b1)     begin n_ov++; buffered++; end
            if (bus1.credit_return === 1'b1) buffered--;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus1.s_valid       = 1'b0;
            bus1.credit_return = 1'b0;
            #2;
            if (bus1.out_valid === 1'b1) n_ov++;
        end
        chk("t6_issue_count_nonzero", longint'(n_iss > 0), 1);
        chk("t6_out_valid_eq_issue", n_ov, n_iss);

        repeat (5) @(posedge clk);
        #3;
        chk("sb_out_valid_drained", ov_q.size(), 0);
        chk("sb_flush_done_drained", fd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
